// File: rtl/cpu_cycle_sequencer.sv
// Cycle sequencer for the 6502-compatible core: two-phase enables, one-hot
// T-state, opcode/previous-opcode latches and RESET/NMI/IRQ arbitration.
module cpu_cycle_sequencer #(
  parameter int unsigned TW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic [7:0]    opIn,
  input  logic          lastCycle,
  input  logic          nmi_n,
  input  logic          irq_n,
  input  logic          statusI,
  output logic          phi1,
  output logic          phi2,
  output logic [TW-1:0] T,
  output logic [7:0]    OP,
  output logic [7:0]    prevOP,
  output logic [2:0]    activeInt,
  output logic          sync,
  output logic          seqErr
);

  typedef enum logic {
    PH1 = 1'b0,
    PH2 = 1'b1
  } phase_t;

  typedef enum logic [2:0] {
    INT_NONE = 3'b000,
    INT_IRQ  = 3'b001,
    INT_NMI  = 3'b010,
    INT_RES  = 3'b100
  } int_t;

  localparam logic [TW-1:0] T1 = {{(TW-1){1'b0}}, 1'b1};

  phase_t        phase, phaseNext;
  int_t          intQ, intNext;
  logic [TW-1:0] tNext;
  logic [7:0]    opNext, prevNext;
  logic          resPend, resPendNext;
  logic          nmiPend, nmiPendNext;
  logic          seqErrNext;
  logic          nmiPrev;
  logic          nmiFall;
  logic          resLive;

  assign nmiFall   = nmiPrev & ~nmi_n;
  assign phi1      = (phase == PH1);
  assign phi2      = (phase == PH2);
  assign sync      = T[0];
  assign activeInt = intQ;

  // RESET is consumed when its service starts (the forced-BRK opcode latch),
  // so a pending reset cannot be re-taken at that sequence's own boundary.
  assign resLive = resPend & ~(T[0] & (intQ == INT_RES));

  always_comb begin
    phaseNext   = phase;
    tNext       = T;
    opNext      = OP;
    prevNext    = prevOP;
    intNext     = intQ;
    resPendNext = resPend;
    nmiPendNext = nmiPend | nmiFall;
    seqErrNext  = seqErr;

    if (phase == PH1) begin
      phaseNext = PH2;
    end else if (rdy) begin
      phaseNext = PH1;

      if (lastCycle) begin
        tNext = T1;
      end else if (T[TW-1]) begin
        tNext      = T1;
        seqErrNext = 1'b1;
      end else begin
        tNext = T << 1;
      end

      if (T[0]) begin
        prevNext = OP;
        opNext   = (intQ != INT_NONE) ? 8'h00 : opIn;
        if (intQ == INT_RES) resPendNext = 1'b0;
      end

      if (lastCycle) begin
        if (resLive) begin
          intNext     = INT_RES;
          resPendNext = 1'b0;
        end else if (nmiPend) begin
          intNext     = INT_NMI;
          nmiPendNext = nmiFall;
        end else if (!irq_n && !statusI) begin
          intNext = INT_IRQ;
        end else begin
          intNext = INT_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= PH1;
      T       <= T1;
      OP      <= '0;
      prevOP  <= '0;
      intQ    <= INT_RES;
      resPend <= 1'b1;
      nmiPend <= 1'b0;
      seqErr  <= 1'b0;
      nmiPrev <= nmi_n;
    end else begin
      phase   <= phaseNext;
      T       <= tNext;
      OP      <= opNext;
      prevOP  <= prevNext;
      intQ    <= intNext;
      resPend <= resPendNext;
      nmiPend <= nmiPendNext;
      seqErr  <= seqErrNext;
      nmiPrev <= nmi_n;
    end
  end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: per-CPU-cycle vector tables
// with a scoreboard queue, plus hand-written reset sequences.
module tb_cpu_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic [7:0] opIn;
  logic       lastCycle;
  logic       nmi_n;
  logic       irq_n;
  logic       statusI;
  logic       phi1, phi2;
  logic [6:0] T;
  logic [7:0] OP, prevOP;
  logic [2:0] activeInt;
  logic       sync, seqErr;

  int errors = 0;
  int checks = 0;

  cpu_cycle_sequencer #(.TW(7)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .opIn(opIn), .lastCycle(lastCycle),
    .nmi_n(nmi_n), .irq_n(irq_n), .statusI(statusI), .phi1(phi1), .phi2(phi2),
    .T(T), .OP(OP), .prevOP(prevOP), .activeInt(activeInt), .sync(sync),
    .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] opv;
    logic       last;
    logic       nmi;
    logic       irqN;
    logic       stI;
    int         stall;
    int         tIdx;
    logic [7:0] expOp;
    logic [7:0] expPrev;
    logic [2:0] expInt;
    logic       expErr;
  } vec_t;

  typedef struct {
    logic [6:0] t;
    logic [7:0] op;
    logic [7:0] prev;
    logic [2:0] ai;
    logic       err;
  } exp_t;

  vec_t vecsA[$];
  vec_t vecsB[$];
  exp_t sb[$];
  logic [6:0] curT;

  function automatic vec_t mk(logic [7:0] opv, logic last, logic nmi, logic irqN,
                              logic stI, int stall, int tIdx, logic [7:0] eOp,
                              logic [7:0] ePrev, logic [2:0] eInt, logic eErr);
    vec_t v;
    v.opv = opv; v.last = last; v.nmi = nmi; v.irqN = irqN; v.stI = stI;
    v.stall = stall; v.tIdx = tIdx; v.expOp = eOp; v.expPrev = ePrev;
    v.expInt = eInt; v.expErr = eErr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkResetValues();
    chk("rst_phi1", phi1, 1);
    chk("rst_phi2", phi2, 0);
    chk("rst_T", T, 7'b0000001);
    chk("rst_OP", OP, 8'h00);
    chk("rst_prevOP", prevOP, 8'h00);
    chk("rst_activeInt", activeInt, 3'b100);
    chk("rst_seqErr", seqErr, 0);
    chk("rst_sync", sync, 1);
  endtask

  // Entry/exit point: just after a negedge, DUT in the phi1 half of a cycle.
  task automatic runCycle(input vec_t v);
    exp_t e;
    chk("phi1_hi", phi1, 1);
    chk("phi2_lo", phi2, 0);
    chk("sync_ph1", sync, (curT == 7'd1));
    opIn = v.opv; lastCycle = v.last; nmi_n = v.nmi; irq_n = v.irqN;
    statusI = v.stI; rdy = 1'b1;
    e.t = 7'(1) << (v.tIdx - 1);
    e.op = v.expOp; e.prev = v.expPrev; e.ai = v.expInt; e.err = v.expErr;
    sb.push_back(e);
    @(negedge clk);
    chk("phi2_hi", phi2, 1);
    chk("T_ph2", T, curT);
    chk("sync_ph2", sync, (curT == 7'd1));
    if (v.stall > 0) begin
      rdy = 1'b0;
      repeat (v.stall) begin
        @(negedge clk);
        chk("stall_phi2", phi2, 1);
        chk("stall_T", T, curT);
      end
      rdy = 1'b1;
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("T", T, e.t);
      chk("OP", OP, e.op);
      chk("prevOP", prevOP, e.prev);
      chk("activeInt", activeInt, e.ai);
      chk("seqErr", seqErr, e.err);
      curT = e.t;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // opv last nmi irqN stI stall | tIdx OP prev int err
    vecsA.push_back(mk(8'hA9, 0, 1, 1, 0, 0, 2, 8'h00, 8'h00, 3'b100, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 3'b000, 0));
    vecsA.push_back(mk(8'hA9, 0, 1, 1, 0, 0, 2, 8'hA9, 8'h00, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 0, 1, 8'hA9, 8'h00, 3'b000, 0));
    vecsA.push_back(mk(8'hE8, 0, 1, 1, 0, 0, 2, 8'hE8, 8'hA9, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 0, 1, 8'hE8, 8'hA9, 3'b000, 0));
    vecsA.push_back(mk(8'hAD, 0, 1, 1, 0, 0, 2, 8'hAD, 8'hE8, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 0, 1, 1, 0, 0, 3, 8'hAD, 8'hE8, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 0, 1, 1, 0, 3, 4, 8'hAD, 8'hE8, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 2, 1, 8'hAD, 8'hE8, 3'b000, 0));
    // NMI edge and unmasked IRQ together: NMI first, then IRQ
    vecsA.push_back(mk(8'h4C, 0, 1, 0, 0, 0, 2, 8'h4C, 8'hAD, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 1, 0, 0, 0, 0, 1, 8'h4C, 8'hAD, 3'b010, 0));
    vecsA.push_back(mk(8'hEA, 0, 1, 0, 0, 0, 2, 8'h00, 8'h4C, 3'b010, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 0, 0, 0, 1, 8'h00, 8'h4C, 3'b001, 0));
    vecsA.push_back(mk(8'hEA, 0, 1, 0, 0, 0, 2, 8'h00, 8'h00, 3'b001, 0));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 3'b000, 0));
    // IRQ masked for four instructions
    for (int i = 0; i < 4; i++) begin
      vecsA.push_back(mk(8'hE8, 0, 1, 0, 1, 0, 2, 8'hE8, (i == 0) ? 8'h00 : 8'hE8, 3'b000, 0));
      vecsA.push_back(mk(8'h00, 1, 1, 0, 1, 0, 1, 8'hE8, (i == 0) ? 8'h00 : 8'hE8, 3'b000, 0));
    end
    // Runaway: no lastCycle, wrap past T7 sets seqErr
    vecsA.push_back(mk(8'h02, 0, 1, 1, 0, 0, 2, 8'h02, 8'hE8, 3'b000, 0));
    for (int i = 3; i <= 7; i++)
      vecsA.push_back(mk(8'h00, 0, 1, 1, 0, 0, i, 8'h02, 8'hE8, 3'b000, 0));
    vecsA.push_back(mk(8'h00, 0, 1, 1, 0, 0, 1, 8'h02, 8'hE8, 3'b000, 1));
    vecsA.push_back(mk(8'hEA, 0, 1, 1, 0, 0, 2, 8'hEA, 8'h02, 3'b000, 1));
    vecsA.push_back(mk(8'h00, 1, 1, 1, 0, 0, 1, 8'hEA, 8'h02, 3'b000, 1));
    // Leave an NMI pending in T3 just before reset
    vecsA.push_back(mk(8'hEA, 0, 1, 1, 0, 0, 2, 8'hEA, 8'hEA, 3'b000, 1));
    vecsA.push_back(mk(8'h00, 0, 0, 1, 0, 0, 3, 8'hEA, 8'hEA, 3'b000, 1));

    // After mid-instruction reset: no stale NMI, then lastCycle exactly at T7
    vecsB.push_back(mk(8'h11, 0, 0, 1, 0, 0, 2, 8'h00, 8'h00, 3'b100, 0));
    vecsB.push_back(mk(8'h00, 1, 0, 1, 0, 0, 1, 8'h00, 8'h00, 3'b000, 0));
    vecsB.push_back(mk(8'h22, 0, 0, 1, 0, 0, 2, 8'h22, 8'h00, 3'b000, 0));
    for (int i = 3; i <= 7; i++)
      vecsB.push_back(mk(8'h00, 0, 0, 1, 0, 0, i, 8'h22, 8'h00, 3'b000, 0));
    vecsB.push_back(mk(8'h00, 1, 0, 1, 0, 0, 1, 8'h22, 8'h00, 3'b000, 0));
    vecsB.push_back(mk(8'h33, 0, 0, 1, 0, 0, 2, 8'h33, 8'h22, 3'b000, 0));

    rst_n = 1'b0; rdy = 1'b1; opIn = 8'h00; lastCycle = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b1; statusI = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst_n = 1'b1;
    curT = 7'd1;

    foreach (vecsA[i]) runCycle(vecsA[i]);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetValues();
    chk("sb_empty", sb.size(), 0);
    rst_n = 1'b1;
    curT = 7'd1;

    foreach (vecsB[i]) runCycle(vecsB[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
